// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B (mod 2^WIDTH) plus final borrow, one bit per clock,
// LSB first, paced by a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             diff_bit,
    output logic             bit_valid
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: difference and borrow-out of x - y - bi
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   a_sr_r, a_sr_s;
    logic [WIDTH-1:0]   b_sr_r, b_sr_s;
    logic [WIDTH-1:0]   res_r, res_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               bin_r, bin_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   diff_r, diff_s;
    logic               borrow_r, borrow_s;
    logic               diff_bit_r, diff_bit_s;
    logic               bit_valid_r, bit_valid_s;
    logic               d_s;
    logic               bout_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_s     = state_r;
        a_sr_s      = a_sr_r;
        b_sr_s      = b_sr_r;
        res_s       = res_r;
        cnt_s       = cnt_r;
        bin_s       = bin_r;
        diff_s      = diff_r;
        borrow_s    = borrow_r;
        done_s      = 1'b0;
        d_s         = fs_diff(a_sr_r[0], b_sr_r[0], bin_r);
        bout_s      = fs_borrow(a_sr_r[0], b_sr_r[0], bin_r);

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_s  = a;
                    b_sr_s  = b;
                    res_s   = '0;
                    bin_s   = 1'b0;
                    cnt_s   = '0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                res_s  = {d_s, res_r[WIDTH-1:1]};
                a_sr_s = {1'b0, a_sr_r[WIDTH-1:1]};
                b_sr_s = {1'b0, b_sr_r[WIDTH-1:1]};
                bin_s  = bout_s;
                cnt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    diff_s   = {d_s, res_r[WIDTH-1:1]};
                    borrow_s = bout_s;
                    done_s   = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s  = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Look ahead one cycle so the registered serial bit lines up with its SHIFT cycle
        busy_s      = (state_s == SHIFT);
        bit_valid_s = busy_s;
        diff_bit_s  = busy_s & fs_diff(a_sr_s[0], b_sr_s[0], bin_s);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            res_r       <= '0;
            cnt_r       <= '0;
            bin_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            diff_r      <= '0;
            borrow_r    <= 1'b0;
            diff_bit_r  <= 1'b0;
            bit_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_sr_r      <= a_sr_s;
            b_sr_r      <= b_sr_s;
            res_r       <= res_s;
            cnt_r       <= cnt_s;
            bin_r       <= bin_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            diff_r      <= diff_s;
            borrow_r    <= borrow_s;
            diff_bit_r  <= diff_bit_s;
            bit_valid_r <= bit_valid_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign diff      = diff_r;
    assign borrow    = borrow_r;
    assign diff_bit  = diff_bit_r;
    assign bit_valid = bit_valid_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, random ops and
// hand-written busy-start, reset-abort and back-to-back sequences, checked via a scoreboard.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       diff_bit;
    logic       bit_valid;

    int         n_vec;
    int         n_fail;
    logic [8:0] sb_q[$];
    logic [7:0] prev_d;
    logic       prev_bo;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vd;
        logic       vbo;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow    (borrow),
        .diff_bit  (diff_bit),
        .bit_valid (bit_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Called right after a negedge; runs one operation to its done pulse.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] ed,
                         input logic eb, input int glitch_k);
        logic [7:0] bits;
        logic [8:0] exp;
        int         nbits;
        bit         got_done;
        bit         busy_ok;
        bits     = 8'd0;
        nbits    = 0;
        got_done = 1'b0;
        busy_ok  = 1'b1;
        a        = ta;
        b        = tb_v;
        start    = 1'b1;
        sb_q.push_back({eb, ed});
        for (int k = 1; k <= 20 && !got_done; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == glitch_k) begin
                start = 1'b1;
                a     = 8'd7;
                b     = 8'd3;
            end
            if (k == glitch_k + 1) start = 1'b0;
            if (bit_valid) begin
                bits = {diff_bit, bits[7:1]};
                nbits++;
            end
            if (busy !== (k <= 8)) busy_ok = 1'b0;
            if (k == 4) begin
                check("diff_held_during_op", int'(diff), int'(prev_d));
                check("borrow_held_during_op", int'(borrow), int'(prev_bo));
            end
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", k, 9);
                if (sb_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    exp = sb_q.pop_front();
                    check("diff", int'(diff), int'(exp[7:0]));
                    check("borrow", int'(borrow), int'(exp[8]));
                    check("serial_stream", int'(bits), int'(exp[7:0]));
                    check("serial_bit_count", nbits, 8);
                    prev_d  = exp[7:0];
                    prev_bo = exp[8];
                end
            end
        end
        check("done_seen", int'(got_done), 1);
        check("busy_profile", int'(busy_ok), 1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         first_done;
        int         second_done;
        n_vec   = 0;
        n_fail  = 0;
        prev_d  = 8'd0;
        prev_bo = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = 8'd0;
        b       = 8'd0;

        vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
        vecs[1] = '{8'd5,   8'd10,  8'hFB,  1'b1};
        vecs[2] = '{8'h5A,  8'h5A,  8'd0,   1'b0};
        vecs[3] = '{8'd0,   8'd255, 8'd1,   1'b1};
        vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
        vecs[5] = '{8'd128, 8'd129, 8'd255, 1'b1};
        vecs[6] = '{8'd1,   8'd1,   8'd0,   1'b0};
        vecs[7] = '{8'h80,  8'h01,  8'h7F,  1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({busy, done, diff, borrow, diff_bit, bit_valid}), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vd, vecs[i].vbo, 0);
        end

        // Result must stay put while idle
        repeat (3) @(negedge clk);
        check("diff_hold_idle", int'(diff), int'(prev_d));
        check("done_low_idle", int'(done), 0);

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, ra - rb, (ra < rb), 0);
        end

        // Start pulsed with other operands while busy: must be ignored
        do_op(8'd100, 8'd1, 8'd99, 1'b0, 3);

        // Reset in the 4th SHIFT cycle aborts the operation
        a     = 8'd200;
        b     = 8'd100;
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", int'({busy, done, diff, borrow, diff_bit, bit_valid}), 0);
        rst     = 1'b0;
        prev_d  = 8'd0;
        prev_bo = 1'b0;
        do_op(8'd9, 8'd3, 8'd6, 1'b0, 0);

        // Back-to-back: start held high through the DONE cycle
        first_done  = 0;
        second_done = 0;
        a     = 8'd20;
        b     = 8'd3;
        start = 1'b1;
        sb_q.push_back({1'b0, 8'd17});
        for (int k = 1; k <= 30 && second_done == 0; k++) begin
            @(negedge clk);
            if (k == 5) begin
                a = 8'd50;
                b = 8'd60;
                sb_q.push_back({1'b1, 8'd246});
            end
            if (k == first_done + 1 && first_done != 0) start = 1'b0;
            if (done) begin
                logic [8:0] exp;
                if (sb_q.size() == 0) begin
                    check("b2b_scoreboard_nonempty", 0, 1);
                end else begin
                    exp = sb_q.pop_front();
                    check("b2b_diff", int'(diff), int'(exp[7:0]));
                    check("b2b_borrow", int'(borrow), int'(exp[8]));
                end
                if (first_done == 0) first_done = k;
                else second_done = k;
            end
        end
        start = 1'b0;
        check("b2b_first_done_cycle", first_done, 9);
        check("b2b_done_spacing", second_done - first_done, 9);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
